// File: rtl/lsu_if.sv
// Data-memory request/response bus between the LSU (master) and the memory (slave).
interface lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_ready;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store stage between EXU and WBU: one memory access in flight, lane alignment and load extension.
// Optional LSU_MISALIGN_CHECK_EN adds misalign_err and suppresses bus access for misaligned halfword/word ops.
package lsu_pkg;
    typedef struct packed {
        logic        valid;
        logic        mem_en;
        logic        mem_wen;
        logic [2:0]  funct3;
        logic [31:0] mem_addr;
        logic [31:0] store_data;
        logic [31:0] exu_result;
        logic [4:0]  rd_addr;
        logic        reg_wen;
        logic [31:0] pc_target;
    } ex_lsu_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] wb_data;
        logic [4:0]  rd_addr;
        logic        reg_wen;
        logic [31:0] pc_target;
    } lsu_wb_t;
endpackage

// state  | meaning
// S_IDLE | ready for a new instruction
// S_REQ  | memory request presented, waiting for mem_req_ready
// S_RESP | waiting for mem_resp_valid (bounded by TIMEOUT_CYC when non-zero)
// S_DONE | result presented to WBU, waiting for out_ready
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  ex_lsu_t in,
    output logic    in_ready,
    output lsu_wb_t out,
    input  logic    out_ready,
    lsu_if.master   mem_bus,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic    misalign_err,
`endif
    output logic    mem_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wait_cnt;
    logic [1:0]  a_lo;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    assign a_lo     = in.mem_addr[1:0];
    assign in_ready = (state == S_IDLE);

    // Lanes past byte 3 simply fall off the shift on misaligned words.
    always_comb begin
        st_wstrb = 4'b1111 << a_lo;
        st_wdata = in.store_data << {a_lo, 3'b000};
        case (in.funct3)
            3'b000: begin
                st_wstrb = 4'b0001 << a_lo;
                st_wdata = {4{in.store_data[7:0]}};
            end
            3'b001: begin
                st_wstrb = 4'b0011 << {a_lo[1], 1'b0};
                st_wdata = {2{in.store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shift = mem_bus.mem_resp_rdata >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic misaligned;

    // Stores only define SB/SH/SW; every other store encoding is treated as a word.
    always_comb begin
        misaligned = 1'b0;
        case (in.funct3)
            3'b000:  misaligned = 1'b0;
            3'b001:  misaligned = a_lo[0];
            3'b100:  misaligned = in.mem_wen ? (a_lo != 2'b00) : 1'b0;
            3'b101:  misaligned = in.mem_wen ? (a_lo != 2'b00) : a_lo[0];
            default: misaligned = (a_lo != 2'b00);
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= S_IDLE;
            out                    <= '0;
            funct3_q               <= '0;
            addr_lo_q              <= '0;
            wait_cnt               <= '0;
            mem_timeout            <= 1'b0;
            mem_bus.mem_req_valid  <= 1'b0;
            mem_bus.mem_req_addr   <= '0;
            mem_bus.mem_req_wen    <= 1'b0;
            mem_bus.mem_req_wdata  <= '0;
            mem_bus.mem_req_wstrb  <= '0;
            mem_bus.mem_resp_ready <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_err           <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in.valid) begin
                        out.wb_data           <= in.exu_result;
                        out.rd_addr           <= in.rd_addr;
                        out.reg_wen           <= in.reg_wen;
                        out.pc_target         <= in.pc_target;
                        funct3_q              <= in.funct3;
                        addr_lo_q             <= a_lo;
                        mem_bus.mem_req_addr  <= in.mem_addr;
                        mem_bus.mem_req_wen   <= in.mem_wen;
                        mem_bus.mem_req_wdata <= in.mem_wen ? st_wdata : 32'h0;
                        mem_bus.mem_req_wstrb <= in.mem_wen ? st_wstrb : 4'b0000;
                        if (!in.mem_en) begin
                            out.valid <= 1'b1;
                            state     <= S_DONE;
`ifdef LSU_MISALIGN_CHECK_EN
                        end else if (misaligned) begin
                            out.valid    <= 1'b1;
                            out.wb_data  <= 32'h0;
                            out.reg_wen  <= 1'b0;
                            misalign_err <= 1'b1;
                            state        <= S_DONE;
`endif
                        end else begin
                            mem_bus.mem_req_valid <= 1'b1;
                            state                 <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_bus.mem_req_ready) begin
                        mem_bus.mem_req_valid  <= 1'b0;
                        mem_bus.mem_resp_ready <= 1'b1;
                        wait_cnt               <= '0;
                        state                  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (mem_bus.mem_resp_valid) begin
                        mem_bus.mem_resp_ready <= 1'b0;
                        out.valid              <= 1'b1;
                        if (!mem_bus.mem_req_wen) out.wb_data <= ld_data;
                        state                  <= S_DONE;
                    end else if (TIMEOUT_CYC != 0 && wait_cnt == TIMEOUT_CYC - 1) begin
                        mem_bus.mem_resp_ready <= 1'b0;
                        out.valid              <= 1'b1;
                        out.wb_data            <= 32'h0;
                        out.reg_wen            <= 1'b0;
                        mem_timeout            <= 1'b1;
                        state                  <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out.valid <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
                        misalign_err <= 1'b0;
`endif
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table plus scoreboard, with timeout/reset/backpressure sequences.
module tb_lsu;
    import lsu_pkg::*;

    typedef struct {
        logic        mem_en;
        logic        mem_wen;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] exu;
        logic [4:0]  rd;
        logic        reg_wen;
        logic [31:0] rdata;
        int          req_delay;
        int          out_delay;
        bit          early_resp;
        logic [31:0] exp_wb;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
    } vec_t;

    logic    clk = 1'b0;
    logic    rst;
    ex_lsu_t ex;
    lsu_wb_t o;
    logic    in_ready;
    logic    out_ready;
    logic    mem_timeout;
`ifdef LSU_MISALIGN_CHECK_EN
    logic    misalign_err;
`endif

    lsu_if mem_bus();

    lsu #(.TIMEOUT_CYC(4)) dut (
        .clk(clk),
        .rst(rst),
        .in(ex),
        .in_ready(in_ready),
        .out(o),
        .out_ready(out_ready),
        .mem_bus(mem_bus.master),
`ifdef LSU_MISALIGN_CHECK_EN
        .misalign_err(misalign_err),
`endif
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    int      n_pass = 0;
    int      n_total = 0;
    lsu_wb_t sb[$];
    lsu_wb_t sb_e;
    vec_t    vecs[$];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Output handshake happens at the next posedge; inputs only change at posedge+1.
    always @(negedge clk) begin
        if (!rst && o.valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                sb_e = sb.pop_front();
                chk("out_wb_data", o.wb_data, sb_e.wb_data);
                chk("out_rd_addr", o.rd_addr, sb_e.rd_addr);
                chk("out_reg_wen", o.reg_wen, sb_e.reg_wen);
                chk("out_pc_target", o.pc_target, sb_e.pc_target);
            end
        end
    end

    task automatic chk_req(input vec_t v);
        chk("req_valid", mem_bus.mem_req_valid, 1);
        chk("req_addr", mem_bus.mem_req_addr, v.addr);
        chk("req_wen", mem_bus.mem_req_wen, v.mem_wen);
        chk("req_wstrb", mem_bus.mem_req_wstrb, v.mem_wen ? v.exp_wstrb : 4'b0000);
        if (v.mem_wen) chk("req_wdata", mem_bus.mem_req_wdata, v.exp_wdata);
        chk("req_in_ready", in_ready, 0);
    endtask

    task automatic run_op(input vec_t v, input logic [31:0] pc);
        @(posedge clk); #1;
        ex            = '0;
        ex.valid      = 1'b1;
        ex.mem_en     = v.mem_en;
        ex.mem_wen    = v.mem_wen;
        ex.funct3     = v.funct3;
        ex.mem_addr   = v.addr;
        ex.store_data = v.sd;
        ex.exu_result = v.exu;
        ex.rd_addr    = v.rd;
        ex.reg_wen    = v.reg_wen;
        ex.pc_target  = pc;
        sb.push_back(lsu_wb_t'{valid: 1'b1, wb_data: v.exp_wb, rd_addr: v.rd,
                               reg_wen: v.reg_wen, pc_target: pc});
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        ex.valid = 1'b0;
        if (v.mem_en) begin
            for (int i = 0; i < v.req_delay; i++) begin
                @(negedge clk);
                chk_req(v);
                @(posedge clk); #1;
            end
            mem_bus.mem_req_ready  = 1'b1;
            mem_bus.mem_resp_valid = v.early_resp;
            mem_bus.mem_resp_rdata = ~v.rdata;
            @(negedge clk);
            chk_req(v);
            @(posedge clk); #1;
            mem_bus.mem_req_ready  = 1'b0;
            mem_bus.mem_resp_valid = 1'b1;
            mem_bus.mem_resp_rdata = v.rdata;
            @(negedge clk);
            chk("resp_ready", mem_bus.mem_resp_ready, 1);
            chk("req_dropped", mem_bus.mem_req_valid, 0);
            @(posedge clk); #1;
            mem_bus.mem_resp_valid = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", o.valid, 1);
        chk("out_in_ready", in_ready, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("misalign_quiet", misalign_err, 0);
`endif
        for (int i = 0; i < v.out_delay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("out_hold_valid", o.valid, 1);
            chk("out_hold_wb", o.wb_data, v.exp_wb);
            chk("out_hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("handshake_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_out_valid", o.valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  got;
        rst                    = 1'b1;
        ex                     = '0;
        out_ready              = 1'b0;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_rdata = '0;

        // mem_en mem_wen f3 addr sd exu rd reg_wen rdata req_dly out_dly early exp_wb exp_wstrb exp_wdata
        vecs.push_back(vec_t'{1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 32'h0, 0, 0, 1'b0, 32'h1234, 4'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 32'h1000_0003, 32'h0, 32'hDEAD_0001, 5'd6, 1'b1, 32'h80FF_0000, 0, 0, 1'b1, 32'hFFFF_FF80, 4'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b100, 32'h1000_0003, 32'h0, 32'hDEAD_0002, 5'd7, 1'b1, 32'h80FF_0000, 0, 0, 1'b0, 32'h0000_0080, 4'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 32'h1000_0002, 32'h0, 32'hDEAD_0003, 5'd8, 1'b1, 32'h8001_1234, 0, 0, 1'b0, 32'hFFFF_8001, 4'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b101, 32'h1000_0000, 32'h0, 32'hDEAD_0004, 5'd9, 1'b1, 32'h1234_F00D, 0, 1, 1'b0, 32'h0000_F00D, 4'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'h0, 32'hDEAD_0005, 5'd10, 1'b1, 32'hDEAD_BEEF, 1, 0, 1'b0, 32'hDEAD_BEEF, 4'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 3'b000, 32'h1000_0001, 32'h0000_00A5, 32'h55, 5'd0, 1'b0, 32'h0, 0, 0, 1'b0, 32'h55, 4'b0010, 32'hA5A5_A5A5});
        vecs.push_back(vec_t'{1'b1, 1'b1, 3'b001, 32'h1000_0002, 32'h0000_ABCD, 32'h66, 5'd0, 1'b0, 32'h0, 3, 2, 1'b0, 32'h66, 4'b1100, 32'hABCD_ABCD});
        vecs.push_back(vec_t'{1'b1, 1'b1, 3'b010, 32'h1000_0008, 32'h1357_9BDF, 32'h77, 5'd0, 1'b0, 32'h0, 0, 0, 1'b0, 32'h77, 4'b1111, 32'h1357_9BDF});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 32'h1000_0001, 32'h0, 32'hDEAD_0006, 5'd11, 1'b1, 32'h0000_7F00, 0, 0, 1'b0, 32'h0000_007F, 4'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b011, 32'h1000_0000, 32'h0, 32'hDEAD_0007, 5'd12, 1'b1, 32'hCAFE_F00D, 0, 0, 1'b1, 32'hCAFE_F00D, 4'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 3'b111, 32'h1000_0004, 32'h2468_ACE0, 32'h99, 5'd0, 1'b0, 32'h0, 0, 0, 1'b0, 32'h99, 4'b1111, 32'h2468_ACE0});
`ifndef LSU_MISALIGN_CHECK_EN
        vecs.push_back(vec_t'{1'b1, 1'b1, 3'b001, 32'h1000_0003, 32'h0000_1122, 32'h88, 5'd0, 1'b0, 32'h0, 0, 0, 1'b0, 32'h88, 4'b1100, 32'h1122_1122});
`endif

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out", o, '0);
        chk("rst_req_valid", mem_bus.mem_req_valid, 0);
        chk("rst_resp_ready", mem_bus.mem_resp_ready, 0);
        chk("rst_timeout", mem_timeout, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("rst_misalign", misalign_err, 0);
`endif

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i], 32'h8000_0000 + 32'(i) * 32'd4);

        // Response never arrives: four S_RESP cycles, then a zero result with no register write.
        chk("tmo_flag_pre", mem_timeout, 0);
        @(posedge clk); #1;
        ex           = '0;
        ex.valid     = 1'b1;
        ex.mem_en    = 1'b1;
        ex.funct3    = 3'b010;
        ex.mem_addr  = 32'h2000_0010;
        ex.exu_result = 32'h5555;
        ex.rd_addr   = 5'd7;
        ex.reg_wen   = 1'b1;
        ex.pc_target = 32'h9000_0000;
        sb.push_back(lsu_wb_t'{valid: 1'b1, wb_data: 32'h0, rd_addr: 5'd7,
                               reg_wen: 1'b0, pc_target: 32'h9000_0000});
        @(posedge clk); #1;
        ex.valid = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_req_ready = 1'b0;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o.valid) begin
                got = 1'b1;
                break;
            end
            if (mem_bus.mem_resp_ready) n++;
        end
        chk("tmo_reached", got, 1);
        chk("tmo_cycles", n, 4);
        chk("tmo_flag", mem_timeout, 1);
        chk("tmo_reg_wen", o.reg_wen, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        run_op(vecs[0], 32'h9000_0004);
        chk("tmo_sticky", mem_timeout, 1);

        // Reset while waiting for a response; the late response must be ignored.
        @(posedge clk); #1;
        ex          = '0;
        ex.valid    = 1'b1;
        ex.mem_en   = 1'b1;
        ex.funct3   = 3'b010;
        ex.mem_addr = 32'h3000_0000;
        ex.rd_addr  = 5'd3;
        ex.reg_wen  = 1'b1;
        @(posedge clk); #1;
        ex.valid = 1'b0;
        mem_bus.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("rstseq_in_resp", mem_bus.mem_resp_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_resp_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        mem_bus.mem_resp_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o.valid) n++;
        end
        chk("rstseq_no_out", n, 0);
        chk("rstseq_in_ready", in_ready, 1);
        chk("rstseq_timeout_clr", mem_timeout, 0);
        chk("rstseq_resp_ready", mem_bus.mem_resp_ready, 0);
        chk("rstseq_req_valid", mem_bus.mem_req_valid, 0);

`ifdef LSU_MISALIGN_CHECK_EN
        @(posedge clk); #1;
        ex           = '0;
        ex.valid     = 1'b1;
        ex.mem_en    = 1'b1;
        ex.funct3    = 3'b010;
        ex.mem_addr  = 32'h4000_0001;
        ex.exu_result = 32'h7777;
        ex.rd_addr   = 5'd9;
        ex.reg_wen   = 1'b1;
        ex.pc_target = 32'hA000_0000;
        sb.push_back(lsu_wb_t'{valid: 1'b1, wb_data: 32'h0, rd_addr: 5'd9,
                               reg_wen: 1'b0, pc_target: 32'hA000_0000});
        @(posedge clk); #1;
        ex.valid = 1'b0;
        @(negedge clk);
        chk("mis_no_req", mem_bus.mem_req_valid, 0);
        chk("mis_out_valid", o.valid, 1);
        chk("mis_err", misalign_err, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mis_err_hold", misalign_err, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("mis_err_clr", misalign_err, 0);
        chk("mis_no_req_after", mem_bus.mem_req_valid, 0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
